router_ctrl: RTL

Ingress controller for the 1x3 router. It accepts a byte stream from the source, decodes the destination from the header, and sequences writes into one of three 16x9 output FIFOs. It handles FIFO-full back-pressure, parity checking, and per-port soft-reset timeouts for FIFOs that are not drained. It sits between the source interface and the three output FIFO instances, and drives their write_enb, lfd_state and soft_reset inputs.

---
 rtl/router_pkg.sv | 32 +++
 rtl/router_ctrl_if.sv | 28 ++
 rtl/router_timeout.sv | 31 +++
 rtl/router_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router ingress controller.
package router_pkg;

  localparam int ADDR_W      = 2;
  localparam int LEN_W       = 6;
  localparam int DATA_W      = 8;
  localparam int NPORT       = 3;
  localparam int TIMEOUT_DEF = 30;
  localparam int TMR_W       = 5;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [3:0] {
    ST_DA   = 4'd0,
    ST_WTE  = 4'd1,
    ST_LFD  = 4'd2,
    ST_LD   = 4'd3,
    ST_FFS  = 4'd4,
    ST_LAF  = 4'd5,
    ST_LP   = 4'd6,
    ST_CPE  = 4'd7,
    ST_DROP = 4'd8
  } state_e;

  // One-hot FIFO select for a decoded destination address.
  function automatic logic [NPORT-1:0] port_sel(input logic [ADDR_W-1:0] addr);
    logic [NPORT-1:0] one;
    one = {{(NPORT-1){1'b0}}, 1'b1};
    return one << addr;
  endfunction

endpackage

// File: rtl/router_ctrl_if.sv
// Source-side and FIFO-side signals of the router ingress controller.
interface router_ctrl_if;
  import router_pkg::*;

  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic [NPORT-1:0]  fifo_full;
  logic [NPORT-1:0]  fifo_empty;
  logic [NPORT-1:0]  read_enb;
  logic              busy;
  logic [DATA_W-1:0] fifo_data;
  logic [NPORT-1:0]  write_enb;
  logic              lfd_state;
  logic [NPORT-1:0]  soft_reset;
  logic [NPORT-1:0]  valid_out;
  logic              parity_err;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    input  busy, fifo_data, write_enb, lfd_state, soft_reset, valid_out, parity_err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    output busy, fifo_data, write_enb, lfd_state, soft_reset, valid_out, parity_err
  );

endinterface

// File: rtl/router_timeout.sv
// Per-port watchdog: pulses soft_reset_o when a non-empty FIFO goes unread too long.
module router_timeout
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  input  logic read_i,
  output logic soft_reset_o
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] cnt_q;

  // Idle-cycle counter; restarts on a read, an empty FIFO, or after firing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!valid_i || read_i || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + TMR_W'(1);
    end
  end

  assign soft_reset_o = (cnt_q == LAST);

endmodule

// File: rtl/router_ctrl.sv
// Ingress controller: decodes the header, sequences FIFO writes, handles
// back-pressure, parity checking and per-port drain timeouts.
module router_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  router_ctrl_if.slave bus_io
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] hdr_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] par_q;
  logic              perr_q;

  logic [NPORT-1:0]  sr_s;
  logic [ADDR_W-1:0] hdr_addr_s;
  logic              full_s;
  logic              sr_abort_s;
  logic              busy_s;
  logic              write_now_s;
  logic              write_s;
  logic [DATA_W-1:0] fifo_data_s;

  for (genvar i = 0; i < NPORT; i++) begin : g_tmo
    router_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (~bus_io.fifo_empty[i]),
      .read_i       (bus_io.read_enb[i]),
      .soft_reset_o (sr_s[i])
    );
  end

  assign hdr_addr_s = bus_io.data_in[ADDR_W-1:0];
  assign full_s     = bus_io.fifo_full[addr_q];
  // A timeout on the port being written abandons the packet in progress.
  assign sr_abort_s = sr_s[addr_q] && !(state_q inside {ST_DA, ST_DROP});
  assign write_s    = write_now_s && !sr_abort_s;

  // Moore busy, write qualification and write-data mux.
  always_comb begin
    busy_s      = 1'b0;
    write_now_s = 1'b0;
    fifo_data_s = hold_q;
    case (state_q)
      ST_LFD: begin
        busy_s      = 1'b1;
        write_now_s = !full_s;
        fifo_data_s = hdr_q;
      end
      ST_LD: begin
        write_now_s = bus_io.pkt_valid && !full_s;
        fifo_data_s = bus_io.data_in;
      end
      ST_LAF, ST_LP: begin
        busy_s      = 1'b1;
        write_now_s = !full_s;
      end
      ST_WTE, ST_FFS, ST_CPE: begin
        busy_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Packet sequencer with its header, hold, parity and error registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_DA;
      addr_q  <= '0;
      hdr_q   <= '0;
      hold_q  <= '0;
      par_q   <= '0;
      perr_q  <= 1'b0;
    end else if (sr_abort_s) begin
      state_q <= bus_io.pkt_valid ? ST_DROP : ST_DA;
    end else begin
      case (state_q)
        ST_DA: begin
          if (bus_io.pkt_valid && (hdr_addr_s != ADDR_INVALID)) begin
            hdr_q   <= bus_io.data_in;
            addr_q  <= hdr_addr_s;
            par_q   <= bus_io.data_in;
            perr_q  <= 1'b0;
            state_q <= bus_io.fifo_empty[hdr_addr_s] ? ST_LFD : ST_WTE;
          end else if (bus_io.pkt_valid) begin
            state_q <= ST_DROP;
          end else begin
            state_q <= ST_DA;
          end
        end
        ST_WTE:  if (bus_io.fifo_empty[addr_q]) state_q <= ST_LFD;
        ST_LFD:  if (!full_s) state_q <= ST_LD;
        ST_LD: begin
          if (bus_io.pkt_valid) begin
            par_q <= par_q ^ bus_io.data_in;
            if (full_s) begin
              hold_q  <= bus_io.data_in;
              state_q <= ST_FFS;
            end
          end else begin
            hold_q  <= bus_io.data_in;
            state_q <= ST_LP;
          end
        end
        ST_FFS:  if (!full_s) state_q <= ST_LAF;
        ST_LAF:  if (!full_s) state_q <= ST_LD;
        ST_LP:   if (!full_s) state_q <= ST_CPE;
        ST_CPE: begin
          perr_q  <= (par_q != hold_q);
          state_q <= ST_DA;
        end
        ST_DROP: if (!bus_io.pkt_valid) state_q <= ST_DA;
        default: state_q <= ST_DA;
      endcase
    end
  end

  assign bus_io.busy       = busy_s;
  assign bus_io.fifo_data  = fifo_data_s;
  assign bus_io.write_enb  = write_s ? port_sel(addr_q) : '0;
  assign bus_io.lfd_state  = (state_q == ST_LFD);
  assign bus_io.soft_reset = sr_s;
  assign bus_io.valid_out  = ~bus_io.fifo_empty;
  assign bus_io.parity_err = perr_q;

endmodule
